// File: rtl/aibcr3_fine_dly_pkg.sv
// Shared types and constants for the fine-delay code controller.
// Code width, settle-counter width, FSM states and the binary-to-Gray helper.
package aibcr3_fine_dly_pkg;

   localparam int unsigned FDLY_CODE_W   = 3;
   localparam int unsigned FDLY_CODE_MAX = 7;
   localparam int unsigned FDLY_CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_VALID  = 2'd3
   } fdly_state_e;

   function automatic logic [FDLY_CODE_W-1:0] bin2gray(input logic [FDLY_CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/aibcr3_fine_dly_settle_cnt.sv
// Loadable 4-bit down-counter timing the settle window; zero flag is combinational.
// Count value is exported only with AIBCR3_FINE_DLY_SCAN_EN so it can join the scan chain.
module aibcr3_fine_dly_settle_cnt
   import aibcr3_fine_dly_pkg::*;
(
   input  logic                  ck,
   input  logic                  nrst,
   input  logic                  i_ld,
   input  logic [FDLY_CNT_W-1:0] i_ld_val,
   input  logic                  i_dec,
`ifdef AIBCR3_FINE_DLY_SCAN_EN
   output logic [FDLY_CNT_W-1:0] o_cnt,
`endif
   output logic                  o_zero_c
);

   logic [FDLY_CNT_W-1:0] r_cnt;

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst)
         r_cnt <= '0;
      else if (i_ld)
         r_cnt <= i_ld_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - FDLY_CNT_W'(1);
   end

   assign o_zero_c = (r_cnt == '0);
`ifdef AIBCR3_FINE_DLY_SCAN_EN
   assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/aibcr3_fine_dly_code_ctrl.sv
// Walks the fine-delay code one LSB per step toward a loaded target, with a settle
// window and a one-cycle code_valid per step. Optional scan chain: AIBCR3_FINE_DLY_SCAN_EN.
module aibcr3_fine_dly_code_ctrl
   import aibcr3_fine_dly_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2
)
(
   input  logic                   ck,
   input  logic                   nrst,
`ifdef AIBCR3_FINE_DLY_SCAN_EN
   input  logic                   se_n,
   input  logic                   si,
   output logic                   so,
`endif
   input  logic [FDLY_CODE_W-1:0] tgt_bin,
   input  logic                   tgt_ld,
   output logic                   ld_rdy,
   output logic [FDLY_CODE_W-1:0] gray,
   output logic                   code_valid,
   output logic [FDLY_CODE_W-1:0] cur_bin,
   output logic                   busy,
   output logic                   done
);

   fdly_state_e            r_state, w_state_nxt;
   logic [FDLY_CODE_W-1:0] r_cur_bin, r_tgt, r_gray;
   logic [FDLY_CODE_W-1:0] w_cur_nxt, w_tgt_nxt;
   logic                   r_code_valid, r_done, r_ld_rdy, r_busy;
   logic                   w_code_valid_nxt, w_done_nxt, w_step_up;
   logic                   w_cnt_ld, w_cnt_dec, w_cnt_zero_c;
   logic                   w_cnt_ld_mux, w_cnt_dec_mux;
   logic [FDLY_CNT_W-1:0]  w_cnt_ld_val, w_cnt_val_mux;

`ifdef AIBCR3_FINE_DLY_SCAN_EN
   localparam int unsigned SCAN_LEN = FDLY_CNT_W + 2 * FDLY_CODE_W + $bits(fdly_state_e);
   logic [FDLY_CNT_W-1:0] w_cnt;
   logic [SCAN_LEN-1:0]   w_chain, w_chain_sh;

   // Chain order from si: state, cur_bin, target, counter, then so.
   assign w_chain       = {w_cnt, r_tgt, r_cur_bin, r_state};
   assign w_chain_sh    = {w_chain[SCAN_LEN-2:0], si};
   assign so            = w_chain[SCAN_LEN-1];
   assign w_cnt_ld_mux  = !se_n || w_cnt_ld;
   assign w_cnt_dec_mux = se_n && w_cnt_dec;
   assign w_cnt_val_mux = se_n ? w_cnt_ld_val : w_chain_sh[SCAN_LEN-1 -: FDLY_CNT_W];
`else
   assign w_cnt_ld_mux  = w_cnt_ld;
   assign w_cnt_dec_mux = w_cnt_dec;
   assign w_cnt_val_mux = w_cnt_ld_val;
`endif

   assign w_cnt_ld_val = FDLY_CNT_W'(SETTLE_CYC - 1);
   assign w_step_up    = (r_tgt > r_cur_bin) && (r_cur_bin != FDLY_CODE_W'(FDLY_CODE_MAX));

   aibcr3_fine_dly_settle_cnt u_settle_cnt (
      .ck       (ck),
      .nrst     (nrst),
      .i_ld     (w_cnt_ld_mux),
      .i_ld_val (w_cnt_val_mux),
      .i_dec    (w_cnt_dec_mux),
`ifdef AIBCR3_FINE_DLY_SCAN_EN
      .o_cnt    (w_cnt),
`endif
      .o_zero_c (w_cnt_zero_c)
   );

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst)
         r_state <= ST_IDLE;
`ifdef AIBCR3_FINE_DLY_SCAN_EN
      else if (!se_n)
         r_state <= fdly_state_e'(w_chain_sh[1:0]);
`endif
      else
         r_state <= w_state_nxt;
   end

   // Next state plus next values of the registered outputs.
   always_comb begin
      w_state_nxt      = r_state;
      w_cur_nxt        = r_cur_bin;
      w_tgt_nxt        = r_tgt;
      w_cnt_ld         = 1'b0;
      w_cnt_dec        = 1'b0;
      w_code_valid_nxt = 1'b0;
      w_done_nxt       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tgt_ld) begin
               w_tgt_nxt = tgt_bin;
               if (tgt_bin != r_cur_bin)
                  w_state_nxt = ST_STEP;
               else
                  w_done_nxt = 1'b1;
            end
         end
         ST_STEP: begin
            w_cur_nxt   = w_step_up ? r_cur_bin + FDLY_CODE_W'(1) : r_cur_bin - FDLY_CODE_W'(1);
            w_cnt_ld    = 1'b1;
            w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (w_cnt_zero_c) begin
               w_state_nxt      = ST_VALID;
               w_code_valid_nxt = 1'b1;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_VALID: begin
            if (r_cur_bin == r_tgt) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_STEP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Code, target and output flops; outputs hold while shifting.
   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         r_cur_bin    <= '0;
         r_tgt        <= '0;
         r_gray       <= '0;
         r_code_valid <= 1'b0;
         r_done       <= 1'b0;
         r_ld_rdy     <= 1'b1;
         r_busy       <= 1'b0;
      end
`ifdef AIBCR3_FINE_DLY_SCAN_EN
      else if (!se_n) begin
         r_cur_bin <= w_chain_sh[4:2];
         r_tgt     <= w_chain_sh[7:5];
      end
`endif
      else begin
         r_cur_bin    <= w_cur_nxt;
         r_tgt        <= w_tgt_nxt;
         r_gray       <= bin2gray(w_cur_nxt);
         r_code_valid <= w_code_valid_nxt;
         r_done       <= w_done_nxt;
         r_ld_rdy     <= (w_state_nxt == ST_IDLE);
         r_busy       <= (w_state_nxt != ST_IDLE);
      end
   end

   assign cur_bin    = r_cur_bin;
   assign gray       = r_gray;
   assign code_valid = r_code_valid;
   assign done       = r_done;
   assign ld_rdy     = r_ld_rdy;
   assign busy       = r_busy;

endmodule
